multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the 3-bit-opcode processor core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, register-file, PC and unified-memory muxes cycle by cycle. It handshakes with a variable-latency memory, counts retired instructions, and traps to a fault state when memory stops responding. It sits between the instruction register and the datapath.

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the 3-bit-opcode core.
// Steps fetch/decode/execute/memory/writeback and drives datapath muxes.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [2:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [3:0]         state,
    output logic               retire,
    output logic [COUNT_W-1:0] retired_cnt,
    output logic               fault
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_FAULT    = 4'd15
    } state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_t        cur;
    state_t        nxt;
    logic [WW-1:0] wait_cnt;
    logic          mem_state;
    logic          timeout;

    assign mem_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    assign timeout   = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
    assign state     = cur;
    assign fault     = (cur == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= S_IDLE;
            wait_cnt    <= '0;
            retired_cnt <= '0;
        end else begin
            cur <= nxt;
            // A state change means a fresh request, so the wait count restarts
            if (nxt != cur || mem_ready)
                wait_cnt <= '0;
            else if (mem_state)
                wait_cnt <= wait_cnt + WW'(1);
            if (retire)
                retired_cnt <= retired_cnt + COUNT_W'(1);
        end
    end

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        case (cur)
            S_IDLE: begin
                if (run)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (timeout) begin
                    nxt = S_FAULT;
                end else if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    3'b000, 3'b001: nxt = S_EXEC_R;
                    3'b111:         nxt = S_EXEC_I;
                    3'b100, 3'b101: nxt = S_MEM_ADDR;
                    3'b110:         nxt = S_BRANCH;
                    3'b010:         nxt = S_JUMP;
                    default:        nxt = S_JAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = (opcode == 3'b001) ? 2'b11 : 2'b10;
                nxt       = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = opcode[0] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (timeout)
                    nxt = S_FAULT;
                else if (mem_ready)
                    nxt = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (timeout)
                    nxt = S_FAULT;
                else if (mem_ready)
                    retire = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                retire     = 1'b1;
            end
            S_FAULT: begin
                nxt = S_FAULT;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
        if (retire)
            nxt = run ? S_FETCH : S_IDLE;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control against an instruction-level model.
// Model tracks per-opcode state paths, memory waits and the retire count.
module tb_multicycle_control;

    localparam int CW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [2:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          reg_write;
    logic [1:0]    reg_dst, mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic [3:0]    state;
    logic          retire;
    logic [CW-1:0] retired_cnt;
    logic          fault;
    logic [16:0]   dut_ctrl;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .retire(retire), .retired_cnt(retired_cnt), .fault(fault)
    );

    assign dut_ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                       reg_write, reg_dst, mem_to_reg, alu_src_a,
                       alu_src_b, alu_op};

    int checks = 0;
    int errors = 0;

    int m_st = 0;
    int m_cnt = 0;
    int m_wait = 0;
    int m_k = 0;
    int m_len = 1;
    int m_path [3];
    bit m_ok = 1'b0;

    function automatic logic [16:0] exp_ctrl(int st, logic [2:0] op,
                                             logic z, logic rdy);
        logic mreq, mwe, io, irw, pcw, rw, asa;
        logic [1:0] psrc, rd, m2r, asb, aop;
        mreq = 0; mwe = 0; io = 0; irw = 0; pcw = 0; rw = 0; asa = 0;
        psrc = 0; rd = 0; m2r = 0; asb = 0; aop = 0;
        case (st)
            1:  begin mreq = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            2:  asb = 2'd3;
            3:  begin asa = 1; aop = (op == 3'd1) ? 2'd3 : 2'd2; end
            4:  begin rw = 1; rd = 2'd1; end
            5:  begin asa = 1; asb = 2'd2; end
            6:  rw = 1;
            7:  begin asa = 1; asb = 2'd2; end
            8:  begin mreq = 1; io = 1; end
            9:  begin rw = 1; m2r = 2'd1; end
            10: begin mreq = 1; io = 1; mwe = 1; end
            11: begin asa = 1; aop = 2'd1; psrc = 2'd1; pcw = z; end
            12: begin pcw = 1; psrc = 2'd2; end
            13: begin rw = 1; rd = 2'd2; m2r = 2'd2; pcw = 1; psrc = 2'd2; end
            default: ;
        endcase
        return {mreq, mwe, io, irw, pcw, psrc, rw, rd, m2r, asa, asb, aop};
    endfunction

    function automatic bit done_now(int st, logic rdy);
        return (st == 4 || st == 6 || st == 9 || st == 11 || st == 12 ||
                st == 13 || (st == 10 && rdy));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit rn, logic [2:0] op, logic rdy);
        if (r) begin
            m_st = 0; m_cnt = 0; m_wait = 0; m_ok = 1'b1;
        end else if (m_st == 15) begin
            m_st = 15;
        end else if (m_st == 0) begin
            if (rn) m_st = 1;
        end else if ((m_st == 1 || m_st == 8 || m_st == 10) && !rdy) begin
            m_wait++;
            if (m_wait == TO) m_st = 15;
        end else begin
            m_wait = 0;
            if (m_st == 1) begin
                m_st = 2;
            end else if (m_st == 2) begin
                case (op)
                    3'd0, 3'd1: begin m_path = '{3, 4, 0}; m_len = 2; end
                    3'd7:       begin m_path = '{5, 6, 0}; m_len = 2; end
                    3'd4:       begin m_path = '{7, 8, 9}; m_len = 3; end
                    3'd5:       begin m_path = '{7, 10, 0}; m_len = 2; end
                    3'd6:       begin m_path = '{11, 0, 0}; m_len = 1; end
                    3'd2:       begin m_path = '{12, 0, 0}; m_len = 1; end
                    default:    begin m_path = '{13, 0, 0}; m_len = 1; end
                endcase
                m_k = 0;
                m_st = m_path[0];
            end else if (m_k == m_len - 1) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_st = rn ? 1 : 0;
            end else begin
                m_k++;
                m_st = m_path[m_k];
            end
        end
    endtask

    task automatic cyc(bit r, bit rn, logic [2:0] op, bit z, bit rdy);
        rst = r; run = rn; opcode = op; zero = z; mem_ready = rdy;
        @(negedge clk);
        if (m_ok) begin
            chk("state", int'(state), m_st);
            chk("ctrl", int'(dut_ctrl), int'(exp_ctrl(m_st, op, z, rdy)));
            chk("retire", int'(retire), int'(done_now(m_st, rdy)));
            chk("retired_cnt", int'(retired_cnt), m_cnt);
            chk("fault", int'(fault), int'(m_st == 15));
        end
        @(posedge clk);
        model_step(r, rn, op, rdy);
        #1;
    endtask

    task automatic instr(logic [2:0] op, bit z, int fw, int mw, bit rn_end,
                         output int n);
        int fl;
        int ml;
        bit fin;
        bit rdy;
        fl = 0; ml = 0; fin = 0; n = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            rdy = 1'b1;
            if (m_st == 1 && fl < fw) begin rdy = 1'b0; fl++; end
            if ((m_st == 8 || m_st == 10) && ml < mw) begin rdy = 1'b0; ml++; end
            fin = done_now(m_st, rdy);
            n++;
            cyc(1'b0, fin ? rn_end : 1'b1, op, z, rdy);
        end
        if (!fin) chk("instr_bound", 0, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; opcode = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("reset_state", int'(state), 0);
        chk("reset_ctrl", int'(dut_ctrl), 0);
        chk("reset_flags", int'({retire, fault}), 0);
        cyc(0, 1, 0, 0, 1);
        chk("start_fetch", int'({state, mem_req}), 5'b0001_1);

        instr(3'd0, 0, 0, 0, 1, n); chk("lat_rtype", n, 4);
        chk("cnt_after_r", int'(retired_cnt), 1);
        instr(3'd1, 0, 0, 0, 1, n); chk("lat_slt", n, 4);
        instr(3'd7, 0, 0, 0, 1, n); chk("lat_addi", n, 4);
        instr(3'd4, 0, 0, 3, 1, n); chk("lat_lw_wait3", n, 8);
        instr(3'd4, 0, 0, 0, 1, n); chk("lat_lw", n, 5);
        instr(3'd5, 0, 0, 0, 1, n); chk("lat_sw", n, 4);
        instr(3'd5, 0, 1, 2, 1, n); chk("lat_sw_waits", n, 7);
        instr(3'd6, 1, 0, 0, 1, n); chk("lat_beq_taken", n, 3);
        instr(3'd6, 0, 0, 0, 1, n); chk("lat_beq_not", n, 3);
        instr(3'd2, 0, 0, 0, 1, n); chk("lat_j", n, 3);
        instr(3'd3, 0, 0, 0, 0, n); chk("lat_jal", n, 3);
        chk("park_idle", int'(state), 0);
        chk("cnt_eleven", int'(retired_cnt), 11);

        // reset while MEM_RD is waiting on memory
        cyc(0, 1, 4, 0, 1);
        cyc(0, 1, 4, 0, 1);
        cyc(0, 1, 4, 0, 1);
        cyc(0, 1, 4, 0, 1);
        chk("in_mem_rd", int'(state), 8);
        cyc(0, 1, 4, 0, 0);
        cyc(1, 1, 4, 0, 0);
        chk("rst_drops_req", int'({state, mem_req}), 0);
        chk("rst_cnt", int'(retired_cnt), 0);

        cyc(0, 1, 0, 0, 1);
        n = 0;
        while (state == 4'd1 && n < 40) begin
            cyc(0, 1, 0, 0, 0);
            n++;
        end
        chk("fault_cycles", n, 15);
        chk("fault_state", int'({state, fault}), 5'b1111_1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("fault_sticky", int'(state), 15);
        cyc(1, 0, 0, 0, 1);
        chk("fault_reset", int'(state), 0);

        cyc(0, 1, 3, 0, 1);
        for (int j = 0; j < 17; j++) begin
            instr(3'd3, 0, 0, 0, (j != 16), n);
            chk("lat_jal_loop", n, 3);
        end
        chk("cnt_wrap", int'(retired_cnt), 1);
        cyc(0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
